writeback_unit: RTL

- Writer side of the integer register file: gathers completed results from three execution sources (ALU, load/store unit, mul/div) and drives the single register-file write port (w_enabled, rd_addr, rd_data).
- Keeps a per-register busy scoreboard used by decode for RAW/WAW hazard checks.
- Sits between the execute units and the register file; one write retired per cycle.

---
 rtl/writeback_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// writeback_unit
//   Writer side of the integer register file. Arbitrates completed results
//   from the load/store unit (mem), mul/div (md) and ALU onto the single
//   register-file write port, and keeps the per-register busy scoreboard
//   that decode uses for RAW/WAW hazard checks.
//
// Ports
//   clk, rstn                    clock, synchronous active-low reset
//   issue_valid/issue_rd         decode issues an instruction writing issue_rd
//   issue_ready                  issue_rd is x0 or not busy
//   alu_*/mem_*/md_*             result channels (valid, rd, data in; ready out)
//   rs1_addr/rs2_addr            decode source queries
//   rs1_busy/rs2_busy            busy bit of each queried register
//   w_enabled/rd_addr/rd_data    registered register-file write port
//   busy                         scoreboard vector (bit 0 always 0)
//   retire_count                 number of grants retired (wraps)
//   err                          sticky: grant to a non-busy, non-zero rd
module writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_ready,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [XLEN-1:0]  md_data,
  output logic             md_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             w_enabled,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  rd_data,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] retire_count,
  output logic             err
);

  logic [31:0]      busy_q, busy_d;
  logic             w_enabled_q, w_enabled_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic             err_q, err_d;

  logic             grant;
  logic [4:0]       g_rd;
  logic [XLEN-1:0]  g_data;
  logic             issue_fire;

  // Fixed priority mem > md > alu.
  always_comb begin
    mem_ready = mem_valid;
    md_ready  = md_valid && !mem_valid;
    alu_ready = alu_valid && !mem_valid && !md_valid;
    grant     = mem_valid || md_valid || alu_valid;
    g_rd      = alu_rd;
    g_data    = alu_data;
    if (mem_valid) begin
      g_rd   = mem_rd;
      g_data = mem_data;
    end else if (md_valid) begin
      g_rd   = md_rd;
      g_data = md_data;
    end
  end

  always_comb begin
    issue_ready = (issue_rd == 5'd0) || !busy_q[issue_rd];
    issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
    rs1_busy    = busy_q[rs1_addr];
    rs2_busy    = busy_q[rs2_addr];
  end

  always_comb begin
    busy_d         = busy_q;
    w_enabled_d    = 1'b0;
    rd_addr_d      = rd_addr_q;
    rd_data_d      = rd_data_q;
    retire_count_d = retire_count_q;
    err_d          = err_q;
    // Clear before set: a same-cycle issue can never target the granted rd
    // (issue_ready is low while busy), so the order only matters for x0.
    if (grant) begin
      busy_d[g_rd]   = 1'b0;
      w_enabled_d    = (g_rd != 5'd0);
      rd_addr_d      = g_rd;
      rd_data_d      = g_data;
      retire_count_d = retire_count_q + CNT_W'(1);
      if ((g_rd != 5'd0) && !busy_q[g_rd]) err_d = 1'b1;
    end
    if (issue_fire) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q         <= '0;
      w_enabled_q    <= 1'b0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      retire_count_q <= '0;
      err_q          <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      w_enabled_q    <= w_enabled_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      retire_count_q <= retire_count_d;
      err_q          <= err_d;
    end
  end

  assign busy         = busy_q;
  assign w_enabled    = w_enabled_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;
  assign retire_count = retire_count_q;
  assign err          = err_q;

endmodule
